// File: rtl/mc_seq_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
// The sequencer owns the request side; memory answers with mem_ready.
interface mc_seq_if;
  logic mem_req;
  logic IorD;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output IorD,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  IorD,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/mc_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer: per-cycle datapath enables,
// memory handshake, wait-state watchdog and retired-instruction counter.
module mc_seq #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             dec_MemRead,
  input  logic             dec_MemWrite,
  input  logic             dec_RegWrite,
  input  logic [1:0]       dec_AddrSrc,
  input  logic             bne,
  input  logic             zero,
  mc_seq_if.master         mem,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             RegWriteEn,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             bus_err,
  output logic [2:0]       state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // The access aborts on the waiting cycle that would bring the counter to MAX_WAIT,
  // so mem_req is never high for more than MAX_WAIT unanswered cycles.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  function automatic logic branch_taken(input logic z, input logic is_bne);
    return z ^ is_bne;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic [CNT_W-1:0] instret_r;
  logic             bus_err_r;

  logic             req_s;
  logic             iord_s;
  logic             we_s;
  logic             irw_s;
  logic             pcw_s;
  logic [1:0]       pcsel_s;
  logic             rwe_s;
  logic             retire_s;
  logic             abort_s;
  logic             waiting_s;

  // Next state and per-cycle enables; everything is held low while rstn is low.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    iord_s      = 1'b0;
    we_s        = 1'b0;
    irw_s       = 1'b0;
    pcw_s       = 1'b0;
    pcsel_s     = 2'd0;
    rwe_s       = 1'b0;
    retire_s    = 1'b0;
    abort_s     = 1'b0;
    if (!rstn) begin
      state_nxt_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (!stall && !bus_err_r) begin
            req_s = 1'b1;
            if (mem.mem_ready) begin
              irw_s       = 1'b1;
              pcw_s       = 1'b1;
              pcsel_s     = 2'd0;
              state_nxt_s = S_DECODE;
            end else if (wait_cnt_r == WAIT_LAST) begin
              abort_s     = 1'b1;
              state_nxt_s = S_FETCH;
            end else begin
              state_nxt_s = S_FETCH;
            end
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
        S_DECODE: begin
          state_nxt_s = S_EXEC;
        end
        S_EXEC: begin
          case (dec_AddrSrc)
            2'd1: begin
              if (branch_taken(zero, bne)) begin
                pcw_s   = 1'b1;
                pcsel_s = 2'd1;
              end else begin
                pcw_s   = 1'b0;
                pcsel_s = 2'd0;
              end
            end
            2'd2, 2'd3: begin
              pcw_s   = 1'b1;
              pcsel_s = dec_AddrSrc;
            end
            default: begin
              pcw_s   = 1'b0;
              pcsel_s = 2'd0;
            end
          endcase
          if (dec_MemRead || dec_MemWrite) begin
            state_nxt_s = S_MEM;
          end else if (dec_RegWrite) begin
            state_nxt_s = S_WB;
          end else begin
            retire_s    = 1'b1;
            state_nxt_s = S_FETCH;
          end
        end
        S_MEM: begin
          if (!bus_err_r) begin
            req_s  = 1'b1;
            iord_s = 1'b1;
            we_s   = dec_MemWrite;
            if (mem.mem_ready) begin
              if (dec_MemRead) begin
                state_nxt_s = S_WB;
              end else begin
                retire_s    = 1'b1;
                state_nxt_s = S_FETCH;
              end
            end else if (wait_cnt_r == WAIT_LAST) begin
              abort_s     = 1'b1;
              state_nxt_s = S_FETCH;
            end else begin
              state_nxt_s = S_MEM;
            end
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
        S_WB: begin
          rwe_s       = 1'b1;
          retire_s    = 1'b1;
          state_nxt_s = S_FETCH;
        end
        default: begin
          state_nxt_s = S_FETCH;
        end
      endcase
    end
  end

  assign waiting_s = req_s & ~mem.mem_ready;

  // State register, watchdog wait counter, sticky bus error and retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= 8'd0;
      instret_r  <= '0;
      bus_err_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // Any state change is an entry into a new access window, so the count restarts.
      if (state_nxt_s != state_r) begin
        wait_cnt_r <= 8'd0;
      end else if (waiting_s) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (abort_s) begin
        bus_err_r <= 1'b1;
      end else begin
        bus_err_r <= bus_err_r;
      end
      if (retire_s) begin
        instret_r <= instret_r + CNT_W'(1);
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign mem.mem_req = req_s;
  assign mem.IorD    = iord_s;
  assign mem.mem_we  = we_s;
  assign IRWrite     = irw_s;
  assign PCWrite     = pcw_s;
  assign PCSel       = pcsel_s;
  assign RegWriteEn  = rwe_s;
  assign retire      = retire_s;
  assign instret     = instret_r;
  assign bus_err     = bus_err_r;
  assign state       = state_r;

endmodule
